a51_stream_decrypt: RTL and testbench



---
 rtl/a51_pkg.sv | 31 +++
 rtl/a51_lfsr_core.sv | 45 ++++
 rtl/a51_stream_decrypt.sv | 159 +++++++++++++++
 tb/tb_a51_stream_decrypt.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/a51_pkg.sv
// Shared A5/1 constants, register geometry and the decrypt-path state encoding.
package a51_pkg;

  localparam int R1_W   = 19;
  localparam int R2_W   = 22;
  localparam int R3_W   = 23;
  localparam int R1_CLK = 8;
  localparam int R2_CLK = 10;
  localparam int R3_CLK = 10;

  // Tap masks: feedback is the XOR of the masked register bits.
  localparam logic [R1_W-1:0] R1_TAPS = 19'h7_2000;   // 18,17,16,13
  localparam logic [R2_W-1:0] R2_TAPS = 22'h30_0000;  // 21,20
  localparam logic [R3_W-1:0] R3_TAPS = 23'h70_0080;  // 22,21,20,7

  localparam int KEY_BITS   = 64;
  localparam int FRAME_BITS = 22;
  localparam logic [FRAME_BITS-1:0] DEFAULT_FRAME = 22'h000134;

  localparam logic MODE_LOAD = 1'b0;
  localparam logic MODE_MAJ  = 1'b1;

  typedef enum logic [2:0] {
    IDLE, LOAD_KEY, LOAD_FRAME, MIX, GEN, WAIT, DONE
  } state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/a51_lfsr_core.sv
// Three A5/1 LFSRs with either unconditional keyed loading or majority stepping.
module a51_lfsr_core
  import a51_pkg::*;
(
  input  logic clk,
  input  logic clrn,
  input  logic clear,
  input  logic mode,
  input  logic step,
  input  logic load_bit,
  output logic ks_bit
);

  logic [R1_W-1:0] r_r1;
  logic [R2_W-1:0] r_r2;
  logic [R3_W-1:0] r_r3;
  logic            w_maj, w_in;
  logic            w_s1, w_s2, w_s3;

  assign w_maj = maj3(r_r1[R1_CLK], r_r2[R2_CLK], r_r3[R3_CLK]);
  // Key/frame bits are only mixed in while loading; majority steps shift in pure feedback.
  assign w_in  = load_bit & (mode == MODE_LOAD);
  assign w_s1  = step & ((mode == MODE_LOAD) | (r_r1[R1_CLK] == w_maj));
  assign w_s2  = step & ((mode == MODE_LOAD) | (r_r2[R2_CLK] == w_maj));
  assign w_s3  = step & ((mode == MODE_LOAD) | (r_r3[R3_CLK] == w_maj));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_r1 <= '0;
      r_r2 <= '0;
      r_r3 <= '0;
    end else if (clear) begin
      r_r1 <= '0;
      r_r2 <= '0;
      r_r3 <= '0;
    end else begin
      if (w_s1) r_r1 <= {r_r1[R1_W-2:0], (^(r_r1 & R1_TAPS)) ^ w_in};
      if (w_s2) r_r2 <= {r_r2[R2_W-2:0], (^(r_r2 & R2_TAPS)) ^ w_in};
      if (w_s3) r_r3 <= {r_r3[R3_W-2:0], (^(r_r3 & R3_TAPS)) ^ w_in};
    end
  end

  assign ks_bit = r_r1[R1_W-1] ^ r_r2[R2_W-1] ^ r_r3[R3_W-1];

endmodule

// File: rtl/a51_stream_decrypt.sv
// A5/1 receive path: key setup, then nibble-wise ciphertext XOR keystream with
// valid/ready on both sides.
module a51_stream_decrypt
  import a51_pkg::*;
#(
  parameter int NIBBLES = 32,
  parameter int WARMUP  = 100
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        start,
  input  logic [63:0] key,
  input  logic [21:0] frame,
  input  logic        ct_valid,
  output logic        ct_ready,
  input  logic [3:0]  ct_data,
  output logic        pt_valid,
  input  logic        pt_ready,
  output logic [3:0]  pt_data,
  output logic        busy,
  output logic        done,
  output logic [4:0]  nib_count
);

  state_e                  r_state, w_state_nxt;
  logic [6:0]              r_cnt, w_cnt_nxt;
  logic [KEY_BITS-1:0]     r_key;
  logic [FRAME_BITS-1:0]   r_frame;
  logic [3:0]              r_ks_nib;
  logic                    r_pt_valid;
  logic [3:0]              r_pt_data;
  logic [4:0]              r_nib_count;
  logic                    r_full;

  logic w_start_acc, w_ct_fire, w_last_nib;
  logic w_step, w_mode, w_load_bit, w_ks_bit;

  assign w_start_acc = start & ((r_state == IDLE) | (r_state == DONE));
  assign ct_ready    = (r_state == WAIT) & (~r_pt_valid | pt_ready);
  assign w_ct_fire   = ct_valid & ct_ready;
  assign w_last_nib  = (r_nib_count == 5'(NIBBLES - 1));

  a51_lfsr_core u_core (
    .clk      (clk),
    .clrn     (clrn),
    .clear    (w_start_acc),
    .mode     (w_mode),
    .step     (w_step),
    .load_bit (w_load_bit),
    .ks_bit   (w_ks_bit)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_step      = 1'b0;
    w_mode      = MODE_LOAD;
    w_load_bit  = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt = LOAD_KEY;
          w_cnt_nxt   = '0;
        end
      end
      LOAD_KEY: begin
        w_step     = 1'b1;
        w_load_bit = r_key[6'(KEY_BITS - 1) - r_cnt[5:0]];
        if (r_cnt == 7'(KEY_BITS - 1)) begin
          w_state_nxt = LOAD_FRAME;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 7'd1;
        end
      end
      LOAD_FRAME: begin
        w_step     = 1'b1;
        w_load_bit = r_frame[5'(FRAME_BITS - 1) - r_cnt[4:0]];
        if (r_cnt == 7'(FRAME_BITS - 1)) begin
          w_state_nxt = MIX;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 7'd1;
        end
      end
      MIX: begin
        w_step = 1'b1;
        w_mode = MODE_MAJ;
        if (r_cnt == 7'(WARMUP - 1)) begin
          w_state_nxt = GEN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 7'd1;
        end
      end
      GEN: begin
        w_step = 1'b1;
        w_mode = MODE_MAJ;
        if (r_cnt == 7'd3) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 7'd1;
        end
      end
      WAIT: begin
        // LFSRs hold here, so a ciphertext stall keeps the keystream position.
        if (w_ct_fire) w_state_nxt = w_last_nib ? DONE : GEN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_key       <= '0;
      r_frame     <= '0;
      r_ks_nib    <= '0;
      r_pt_valid  <= 1'b0;
      r_pt_data   <= '0;
      r_nib_count <= '0;
      r_full      <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_key       <= key;
        r_frame     <= frame;
        r_nib_count <= '0;
        r_full      <= 1'b0;
      end
      if (r_state == GEN) r_ks_nib <= {r_ks_nib[2:0], w_ks_bit};
      // A load wins over a drain, so a same-cycle drain+load keeps pt_valid high.
      if (w_ct_fire) begin
        r_pt_data  <= ct_data ^ r_ks_nib;
        r_pt_valid <= 1'b1;
        if (!r_full) r_nib_count <= r_nib_count + 5'd1;
        if (w_last_nib) r_full <= 1'b1;
      end else if (pt_ready) begin
        r_pt_valid <= 1'b0;
      end
    end
  end

  assign pt_valid  = r_pt_valid;
  assign pt_data   = r_pt_data;
  assign nib_count = r_nib_count;
  assign busy      = (r_state != IDLE) & (r_state != DONE);
  assign done      = (r_state == DONE);

endmodule

// File: tb/tb_a51_stream_decrypt.sv
// Directed bench for a51_stream_decrypt with an independent A5/1 keystream model.
module tb_a51_stream_decrypt;
  import a51_pkg::*;

  logic        clk = 1'b0;
  logic        clrn, start, ct_valid, pt_ready;
  logic [63:0] key;
  logic [21:0] frame;
  logic [3:0]  ct_data;
  logic        ct_ready, pt_valid, busy, done;
  logic [3:0]  pt_data;
  logic [4:0]  nib_count;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  a51_stream_decrypt #(.NIBBLES(32), .WARMUP(100)) dut (
    .clk(clk), .clrn(clrn), .start(start), .key(key), .frame(frame),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
    .busy(busy), .done(done), .nib_count(nib_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Straight-from-the-algorithm keystream: 64 key + 22 frame loads, 100 discards, 128 bits.
  function automatic logic [127:0] model_ks(input logic [63:0] k, input logic [21:0] f);
    logic [18:0]  a;
    logic [21:0]  b;
    logic [22:0]  c;
    logic         m;
    logic [127:0] ks;
    a = '0; b = '0; c = '0; ks = '0;
    for (int i = 63; i >= 0; i--) begin
      a = {a[17:0], a[18] ^ a[17] ^ a[16] ^ a[13] ^ k[i]};
      b = {b[20:0], b[21] ^ b[20] ^ k[i]};
      c = {c[21:0], c[22] ^ c[21] ^ c[20] ^ c[7] ^ k[i]};
    end
    for (int i = 21; i >= 0; i--) begin
      a = {a[17:0], a[18] ^ a[17] ^ a[16] ^ a[13] ^ f[i]};
      b = {b[20:0], b[21] ^ b[20] ^ f[i]};
      c = {c[21:0], c[22] ^ c[21] ^ c[20] ^ c[7] ^ f[i]};
    end
    for (int i = 0; i < 228; i++) begin
      if (i >= 100) ks[227 - i] = a[18] ^ b[21] ^ c[22];
      m = (a[8] & b[10]) | (a[8] & c[10]) | (b[10] & c[10]);
      if (a[8] == m)  a = {a[17:0], a[18] ^ a[17] ^ a[16] ^ a[13]};
      if (b[10] == m) b = {b[20:0], b[21] ^ b[20]};
      if (c[10] == m) c = {c[21:0], c[22] ^ c[21] ^ c[20] ^ c[7]};
    end
    return ks;
  endfunction

  task automatic do_start(input logic [63:0] k, input logic [21:0] f);
    @(negedge clk);
    start = 1'b1;
    key   = k;
    frame = f;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Streams ct, checks every drained pt nibble against exp. Iteration k sits
  // k edges after the start edge.
  task automatic run_frame(input logic [127:0] ct, input logic [127:0] exp,
                           input int stall_at, input bit gaps, input int glitch_k,
                           input int abort_at, output int first_rdy);
    int       sent, got, stall_left;
    bit       stalled, fin;
    logic [3:0] hold;
    sent = 0; got = 0; stall_left = 0; stalled = 0; fin = 0; hold = '0;
    first_rdy = -1;
    for (int k = 0; k < 3000; k++) begin
      if (!stalled && stall_at >= 0 && got == stall_at && pt_valid) begin
        stalled    = 1;
        stall_left = 20;
        hold       = pt_data;
      end
      pt_ready = (stall_left == 0);
      ct_valid = (sent < 32) && !(gaps && (k % 3 == 1));
      ct_data  = (sent < 32) ? ct[127 - 4*sent -: 4] : 4'h0;
      start    = (k == glitch_k);
      if (k == glitch_k) begin
        key   = ~key;
        frame = ~frame;
      end
      #1;
      if (ct_ready && first_rdy < 0) first_rdy = k;
      if (stall_left > 0) begin
        if (stall_left == 1) begin
          chk("bp_pt_data", pt_data, hold);
          chk("bp_pt_valid", pt_valid, 1);
          chk("bp_ct_ready", ct_ready, 0);
        end
        stall_left--;
      end
      if (ct_valid && ct_ready) sent++;
      if (pt_valid && pt_ready) begin
        chk($sformatf("pt%0d", got), pt_data, exp[127 - 4*got -: 4]);
        got++;
      end
      if (got == 32 || (abort_at >= 0 && sent == abort_at)) begin
        fin = 1;
        break;
      end
      @(negedge clk);
    end
    if (!fin) chk("timeout", got, 32);
  endtask

  task automatic end_of_frame_checks(input string tag);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_nibcnt_wrap"}, nib_count, 0);
    @(negedge clk);
    chk({tag, "_pt_drained"}, pt_valid, 0);
  endtask

  initial begin
    logic [127:0] ct, ks2, ks3, msg;
    logic [63:0]  key2, key3;
    logic [21:0]  frame3;
    int           fr;

    clrn = 1'b0; start = 1'b0; ct_valid = 1'b0; pt_ready = 1'b0;
    key = '0; frame = '0; ct_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_ct_ready", ct_ready, 0);
    chk("rst_pt_valid", pt_valid, 0);
    chk("rst_pt_data", pt_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_nib_count", nib_count, 0);
    clrn = 1'b1;

    // All-zero key/frame keeps every LFSR at 0, so plaintext equals ciphertext.
    for (int i = 0; i < 32; i++) ct[127 - 4*i -: 4] = 4'(i);
    do_start(64'h0, 22'h0);
    run_frame(ct, ct, -1, 0, -1, -1, fr);
    chk("zero_first_ready", fr, 190);
    end_of_frame_checks("zero");

    key2 = 64'h1223456789ABCDEF;
    ks2  = model_ks(key2, DEFAULT_FRAME);
    do_start(key2, DEFAULT_FRAME);
    chk("restart_nib_count", nib_count, 0);
    chk("restart_busy", busy, 1);
    chk("restart_done", done, 0);
    run_frame('0, ks2, 10, 0, -1, -1, fr);
    chk("ks_first_ready", fr, 190);
    end_of_frame_checks("ks");

    key3   = {$urandom, $urandom};
    frame3 = 22'($urandom);
    msg    = {$urandom, $urandom, $urandom, $urandom};
    ks3    = model_ks(key3, frame3);
    do_start(key3, frame3);
    run_frame(msg ^ ks3, msg, -1, 1, -1, -1, fr);
    end_of_frame_checks("rt");

    // Reset in MIX (edge ~120 after start).
    do_start(key2, DEFAULT_FRAME);
    repeat (120) @(negedge clk);
    chk("mix_busy_pre", busy, 1);
    clrn = 1'b0;
    #1;
    chk("mix_rst_busy", busy, 0);
    chk("mix_rst_ct_ready", ct_ready, 0);
    chk("mix_rst_nib_count", nib_count, 0);
    @(negedge clk);
    clrn = 1'b1;

    // Reset in WAIT with a plaintext nibble still pending.
    do_start(key2, DEFAULT_FRAME);
    run_frame('0, ks2, -1, 0, -1, 5, fr);
    @(negedge clk);
    ct_valid = 1'b0;
    pt_ready = 1'b0;
    repeat (6) @(negedge clk);
    chk("wait_pt_valid_pre", pt_valid, 1);
    chk("wait_nib_count_pre", nib_count, 5);
    chk("wait_pt_data_pre", pt_data, ks2[127 - 16 -: 4]);
    clrn = 1'b0;
    #1;
    chk("wait_rst_pt_valid", pt_valid, 0);
    chk("wait_rst_pt_data", pt_data, 0);
    chk("wait_rst_nib_count", nib_count, 0);
    chk("wait_rst_busy", busy, 0);
    chk("wait_rst_done", done, 0);
    chk("wait_rst_ct_ready", ct_ready, 0);
    @(negedge clk);
    clrn = 1'b1;

    do_start(key2, DEFAULT_FRAME);
    run_frame('0, ks2, -1, 0, -1, -1, fr);
    chk("post_rst_first_ready", fr, 190);
    end_of_frame_checks("post_rst");

    // start pulsed during GEN must be ignored.
    do_start(key2, DEFAULT_FRAME);
    run_frame('0, ks2, -1, 0, 187, -1, fr);
    chk("glitch_first_ready", fr, 190);
    end_of_frame_checks("glitch");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
